// File: rtl/ram_ctrl_pkg.sv
// Shared widths, tie-off constants, controller state type and the
// byte-select to bit-mask helper used by ram16k_wb_ctrl.
package ram_ctrl_pkg;

    localparam int RAM_AW = 14;
    localparam int RAM_DW = 32;

    localparam logic [RAM_AW-1:0] RAM_IA_NONE = 14'h0;
    localparam logic [5:0]        RAM_FO_NONE = 6'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } ram_ctrl_state_t;

    // A cleared byte select protects all eight bits of that lane.
    function automatic logic [RAM_DW-1:0] sel_to_mask(input logic [RAM_DW/8-1:0] sel);
        logic [RAM_DW-1:0] mask;
        for (int k = 0; k < RAM_DW/8; k++) begin
            mask[8*k +: 8] = {8{~sel[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram_sleep_timer.sv
// Idle and wake counters for the RAM controller: go_sleep flags the last
// idle cycle before sleep, wake_done flags the last cycle of the wake window.
module ram_sleep_timer #(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic idle_inc,
    input  logic idle_clr,
    input  logic wake_en,
    output logic go_sleep,
    output logic wake_done
);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;

    assign go_sleep  = (IDLE_CYCLES != 0) && (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1));
    assign wake_done = wake_en && (wake_cnt_q == CNT_W'(WAKE_CYCLES - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (idle_clr) begin
            idle_cnt_d = '0;
        end else if (idle_inc && (idle_cnt_q != '1)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        wake_cnt_d = '0;
        if (wake_en && !wake_done) begin
            wake_cnt_d = wake_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

endmodule

// File: rtl/ram16k_wb_ctrl.sv
// Wishbone classic slave for a 16Kx32 1RW sleep-capable SRAM macro.
// Define RAM_SLEEP_EN to build the idle timer and the SLEEP/WAKE path.
module ram16k_wb_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned WAKE_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [RAM_AW-1:0] wb_adr,
    input  logic [3:0]        wb_sel,
    input  logic [RAM_DW-1:0] wb_dat_i,
    output logic [RAM_DW-1:0] wb_dat_o,
    output logic              wb_ack,
    output logic              sleep_o,
    input  logic [RAM_DW-1:0] ram_a,
    output logic [RAM_DW-1:0] ram_i,
    output logic [RAM_DW-1:0] ram_dm,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_slp,
    output logic [RAM_AW-1:0] ram_ia,
    output logic [5:0]        ram_fo
);

    ram_ctrl_state_t state_q, state_d;
    logic            we_q, we_d;
    logic            req;
    logic            access;
    logic            go_sleep;
    logic            wake_done;

    assign req    = wb_cyc & wb_stb;
    assign access = (state_q == IDLE) & req & ~rst;

    // A request always beats idle-timer expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
                    we_d    = wb_we;
                end else if (go_sleep) begin
                    state_d = SLEEP;
                end
            end
            RESP:    state_d = IDLE;
            SLEEP:   if (req) state_d = WAKE;
            WAKE:    if (wake_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    assign ram_ce   = access;
    assign ram_we   = access & wb_we;
    assign ram_addr = access ? wb_adr : '0;
    assign ram_i    = access ? wb_dat_i : '0;
    assign ram_dm   = ram_we ? sel_to_mask(wb_sel) : '1;
    assign ram_ia   = RAM_IA_NONE;
    assign ram_fo   = RAM_FO_NONE;

    // Macro read data appears the cycle after CE, which is the ack cycle.
    assign wb_ack   = (state_q == RESP);
    assign wb_dat_o = (wb_ack && !we_q) ? ram_a : '0;

`ifdef RAM_SLEEP_EN
    logic idle_inc;
    assign idle_inc = (state_q == IDLE) & ~req;

    ram_sleep_timer #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (CNT_W)
    ) u_sleep_timer (
        .clk       (clk),
        .rst       (rst),
        .idle_inc  (idle_inc),
        .idle_clr  (~idle_inc),
        .wake_en   (state_q == WAKE),
        .go_sleep  (go_sleep),
        .wake_done (wake_done)
    );

    assign ram_slp = (state_q == SLEEP);
`else
    // Without the sleep path SLEEP and WAKE are unreachable.
    localparam int unsigned TIMER_CFG = IDLE_CYCLES + WAKE_CYCLES + CNT_W;
    assign go_sleep  = 1'b0;
    assign wake_done = (TIMER_CFG != 0);
    assign ram_slp   = 1'b0;
`endif

    assign sleep_o = ram_slp;

endmodule

// File: tb/tb_ram16k_wb_ctrl.sv
// Randomised scoreboard bench for ram16k_wb_ctrl with a behavioural SRAM
// macro and a byte-lane reference memory; follows RAM_SLEEP_EN if defined.
module tb_ram16k_wb_ctrl;

    localparam int IDLE_CYCLES = 8;
    localparam int WAKE_CYCLES = 4;
`ifdef RAM_SLEEP_EN
    localparam bit SLEEP_EN = 1'b1;
`else
    localparam bit SLEEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [13:0] wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o, ram_i, ram_dm;
    logic        wb_ack, sleep_o, ram_ce, ram_we, ram_slp;
    logic [13:0] ram_addr, ram_ia;
    logic [5:0]  ram_fo;
    logic [31:0] ram_a = '0;

    typedef struct { logic [13:0] adr; logic we; logic [31:0] dm; logic [31:0] wdat; } acc_t;
    typedef struct { int cyc; logic [31:0] rdat; } ack_t;

    acc_t      acc_q[$];
    ack_t      ack_q[$];
    bit [31:0] macro_mem [16384];
    bit [31:0] ref_mem   [16384];
    int        vectors = 0;
    int        miscompares = 0;
    int        cyc_cnt = 0;
    int        idle_run = 0;
    bit        done = 1'b0;

    ram16k_wb_ctrl #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .WAKE_CYCLES (WAKE_CYCLES),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .sleep_o  (sleep_o),
        .ram_a    (ram_a),
        .ram_i    (ram_i),
        .ram_dm   (ram_dm),
        .ram_ce   (ram_ce),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_slp  (ram_slp),
        .ram_ia   (ram_ia),
        .ram_fo   (ram_fo)
    );

    always #5 clk = ~clk;

    // Behavioural macro: masked write, registered read data.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (ram_ce) begin
            if (ram_we) macro_mem[ram_addr] <= (macro_mem[ram_addr] & ram_dm) | (ram_i & ~ram_dm);
            else        ram_a <= macro_mem[ram_addr];
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = sel[b] ? 8'h00 : 8'hFF;
        return m;
    endfunction

    // Monitor: every macro access and every ack must match the next expectation.
    always @(negedge clk) begin
        if (!done) begin
            if (ram_ce) begin
                check_output("ce_while_sleep", ram_slp, 1'b0);
                if (acc_q.size() == 0) begin
                    check_output("spurious_ce", ram_ce, 1'b0);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check_output("acc_addr_we", {ram_addr, ram_we}, {a.adr, a.we});
                    check_output("acc_dm", ram_dm, a.dm);
                    check_output("acc_wdat", ram_i, a.wdat);
                end
            end
            if (wb_ack) begin
                if (ack_q.size() == 0) begin
                    check_output("spurious_ack", wb_ack, 1'b0);
                end else begin
                    ack_t k;
                    k = ack_q.pop_front();
                    check_output("ack_cycle", 64'(cyc_cnt), 64'(k.cyc));
                    check_output("ack_data", wb_dat_o, k.rdat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
        idle_run += n;
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        check_output("rst_ack", wb_ack, 1'b0);
        check_output("rst_dat_o", wb_dat_o, 32'h0);
        check_output("rst_ce_we", {ram_ce, ram_we}, 2'b00);
        check_output("rst_slp", {ram_slp, sleep_o}, 2'b00);
        check_output("rst_dm", ram_dm, 32'hFFFF_FFFF);
        check_output("rst_addr_i", {ram_addr, ram_i}, 46'h0);
        check_output("rst_ia_fo", {ram_ia, ram_fo}, 20'h0);
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        check_reset_values();
        tick();
        idle_run = 1;
    endtask

    // Queue expectations from the current sleep status and drive the request.
    task automatic issue(input logic we, input logic [13:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat);
        bit   asleep;
        acc_t a;
        ack_t k;
        asleep = SLEEP_EN && (idle_run >= IDLE_CYCLES);
        lat    = asleep ? WAKE_CYCLES + 2 : 1;
        check_output("sleep_before_req", sleep_o, asleep);
        a.adr = adr; a.we = we; a.wdat = dat;
        a.dm  = we ? lane_mask(sel) : 32'hFFFF_FFFF;
        acc_q.push_back(a);
        k.cyc  = cyc_cnt + lat;
        k.rdat = we ? 32'h0 : ref_mem[adr];
        ack_q.push_back(k);
        if (we) for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
    endtask

    task automatic apply_stimulus(input logic we, input logic [13:0] adr, input logic [3:0] sel,
                                  input logic [31:0] dat);
        int lat;
        issue(we, adr, sel, dat, lat);
        for (int i = 1; i <= lat + 1; i++) begin
            tick();
            if (i == 1) begin
                @(negedge clk);
                check_output("sleep_after_req", sleep_o, 1'b0);
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        idle_run = 0;
    endtask

    task automatic sleep_request_start();
        if (idle_run < IDLE_CYCLES) idle(IDLE_CYCLES + 1 - idle_run);
        check_output("asleep_before_wake", sleep_o, 1'b1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 14'h0001;
        tick();
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    initial begin
        int lat;
        reset_pulse(3);

        // Sleep entry after reset, then an access from sleep.
        repeat (6) tick();
        @(negedge clk);
        check_output("slp_cycle7", {ram_slp, ram_ce}, 2'b00);
        tick();
        @(negedge clk);
        check_output("slp_cycle8", {ram_slp, ram_ce}, {SLEEP_EN, 1'b0});
        tick();
        idle_run = 9;
        apply_stimulus(1'b0, 14'h0001, 4'h0, 32'h0);

        apply_stimulus(1'b1, 14'h0123, 4'hF, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 14'h0123, 4'h0, 32'h0);
        apply_stimulus(1'b1, 14'h3FFF, 4'hF, 32'h1122_3344);
        apply_stimulus(1'b1, 14'h3FFF, 4'h5, 32'hAABB_CCDD);
        apply_stimulus(1'b0, 14'h3FFF, 4'h0, 32'h0);
        apply_stimulus(1'b1, 14'h0040, 4'h0, 32'h5555_5555);
        apply_stimulus(1'b0, 14'h0040, 4'h0, 32'h0);

        // Request lands on the idle-expiry cycle.
        idle(IDLE_CYCLES - 1);
        apply_stimulus(1'b0, 14'h0123, 4'h0, 32'h0);

        // Reset during the ack cycle of a write.
        issue(1'b1, 14'h0200, 4'hF, 32'hCAFE_F00D, lat);
        tick();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        reset_pulse(1);
        apply_stimulus(1'b0, 14'h0200, 4'h0, 32'h0);

`ifdef RAM_SLEEP_EN
        // Master abandons the cycle while the macro wakes.
        sleep_request_start();
        repeat (WAKE_CYCLES - 1) tick();
        idle_run = 0;
        apply_stimulus(1'b0, 14'h3FFF, 4'h0, 32'h0);

        // Reset while waking.
        sleep_request_start();
        reset_pulse(1);
        apply_stimulus(1'b0, 14'h0123, 4'h0, 32'h0);
`else
        for (int i = 0; i < 10; i++) begin
            repeat (100) tick();
            @(negedge clk);
            check_output("no_sleep_1000", {ram_slp, sleep_o}, 2'b00);
        end
        tick();
        idle_run = 0;
`endif

        for (int t = 0; t < 40; t++) begin
            int          r;
            logic [13:0] adr;
            r = $urandom_range(0, 5);
            if (r < 3)       idle(r);
            else if (r == 3) idle(IDLE_CYCLES - 1);
            else if (r == 4) idle(IDLE_CYCLES);
            else             idle(IDLE_CYCLES + 2);
            adr = 14'h01F0 + 14'($urandom_range(0, 15));
            apply_stimulus(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom);
        end

        repeat (4) tick();
        done = 1'b1;
        check_output("acc_left", 64'(acc_q.size()), 64'h0);
        check_output("ack_left", 64'(ack_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
